// File: rtl/heart_pattern_decoder.sv
// Receive-side checker for the 12-line column pattern: locks on blank gaps, captures
// one frame of columns, compares against EXP_PATTERN and keeps pass/error counts.
module heart_pattern_decoder #(
    parameter int unsigned             NUM_COLS    = 12,
    parameter int unsigned             BLANK_RUN   = 2,
    parameter logic [12*NUM_COLS-1:0]  EXP_PATTERN =
        144'h038_07C_0FE_1FE_3FC_7F8_7F8_3FC_1FE_0FE_07C_038
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        signal1,
    input  logic        signal2,
    input  logic        signal3,
    input  logic        signal4,
    input  logic        signal5,
    input  logic        signal6,
    input  logic        signal7,
    input  logic        signal8,
    input  logic        signal9,
    input  logic        signal10,
    input  logic        signal11,
    input  logic        signal12,
    output logic        locked,
    output logic        frame_done,
    output logic        frame_ok,
    output logic [4:0]  col_count,
    output logic [15:0] mismatch_mask,
    output logic [15:0] frame_cnt,
    output logic [15:0] err_cnt,
    output logic        overflow
);

    typedef enum logic [2:0] {
        S_HUNT,
        S_ARMED,
        S_CAPTURE,
        S_DONE,
        S_OVERFLOW
    } state_t;

    state_t      r_state;
    logic [11:0] r_col_q;
    logic        r_col_vld;
    logic [3:0]  r_zrun;
    logic [4:0]  r_idx;
    logic [11:0] r_buf [NUM_COLS];

    logic        r_locked;
    logic        r_frame_done;
    logic        r_frame_ok;
    logic [4:0]  r_col_count;
    logic [15:0] r_mask;
    logic [15:0] r_frame_cnt;
    logic [15:0] r_err_cnt;
    logic        r_overflow;

    logic [11:0] w_col_in;
    logic        w_blank;
    logic [15:0] w_mask;
    logic        w_store0;
    logic        w_store_n;

    assign w_col_in = {signal12, signal11, signal10, signal9, signal8, signal7,
                       signal6, signal5, signal4, signal3, signal2, signal1};
    assign w_blank  = (r_col_q == '0);

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == '1) ? v : v + 16'd1;
    endfunction

    // Missing columns (k >= captured count) are flagged too, so short frames fail.
    always_comb begin
        w_mask = '0;
        for (int unsigned k = 0; k < NUM_COLS; k++) begin
            if (5'(k) < r_idx)
                w_mask[k] = (r_buf[k] != EXP_PATTERN[12*k +: 12]);
            else
                w_mask[k] = 1'b1;
        end
    end

    assign w_store0  = r_col_vld && !w_blank && (r_state == S_ARMED || r_state == S_DONE);
    assign w_store_n = r_col_vld && !w_blank && (r_state == S_CAPTURE) &&
                       (32'(r_idx) < NUM_COLS);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned k = 0; k < NUM_COLS; k++)
                r_buf[k] <= '0;
        end else if (w_store0) begin
            r_buf[0] <= r_col_q;
        end else if (w_store_n) begin
            for (int unsigned k = 0; k < NUM_COLS; k++)
                if (5'(k) == r_idx)
                    r_buf[k] <= r_col_q;
        end
    end

    // The reset value of r_col_q is not a real sample; r_col_vld keeps it out of the lock count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_HUNT;
            r_col_q      <= '0;
            r_col_vld    <= 1'b0;
            r_zrun       <= '0;
            r_idx        <= '0;
            r_locked     <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_ok   <= 1'b0;
            r_col_count  <= '0;
            r_mask       <= '0;
            r_frame_cnt  <= '0;
            r_err_cnt    <= '0;
            r_overflow   <= 1'b0;
        end else begin
            r_col_q      <= w_col_in;
            r_col_vld    <= 1'b1;
            r_frame_done <= 1'b0;
            r_overflow   <= 1'b0;
            if (r_col_vld) begin
                case (r_state)
                    S_HUNT: begin
                        if (!w_blank) begin
                            r_zrun <= '0;
                        end else if (32'(r_zrun) + 32'd1 >= BLANK_RUN) begin
                            r_zrun   <= '0;
                            r_state  <= S_ARMED;
                            r_locked <= 1'b1;
                        end else begin
                            r_zrun <= r_zrun + 4'd1;
                        end
                    end
                    S_ARMED, S_DONE: begin
                        if (w_blank) begin
                            r_state <= S_ARMED;
                        end else begin
                            r_idx   <= 5'd1;
                            r_state <= S_CAPTURE;
                        end
                    end
                    S_CAPTURE: begin
                        if (w_blank) begin
                            r_state      <= S_DONE;
                            r_frame_done <= 1'b1;
                            r_col_count  <= r_idx;
                            r_mask       <= w_mask;
                            r_frame_ok   <= (w_mask == '0);
                            r_frame_cnt  <= sat_inc(r_frame_cnt);
                            if (w_mask != '0)
                                r_err_cnt <= sat_inc(r_err_cnt);
                        end else if (32'(r_idx) < NUM_COLS) begin
                            r_idx <= r_idx + 5'd1;
                        end else begin
                            r_state    <= S_OVERFLOW;
                            r_overflow <= 1'b1;
                            r_locked   <= 1'b0;
                            r_err_cnt  <= sat_inc(r_err_cnt);
                        end
                    end
                    S_OVERFLOW: begin
                        r_state <= S_HUNT;
                        r_zrun  <= '0;
                    end
                    default: begin
                        r_state  <= S_HUNT;
                        r_zrun   <= '0;
                        r_locked <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign locked        = r_locked;
    assign frame_done    = r_frame_done;
    assign frame_ok      = r_frame_ok;
    assign col_count     = r_col_count;
    assign mismatch_mask = r_mask;
    assign frame_cnt     = r_frame_cnt;
    assign err_cnt       = r_err_cnt;
    assign overflow      = r_overflow;

endmodule

// File: tb/tb_heart_pattern_decoder.sv
// Scoreboard bench for heart_pattern_decoder: directed frames push expected reports,
// a negedge monitor pops and compares on every frame_done/overflow pulse.
module tb_heart_pattern_decoder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [11:0] sig = '0;
    logic        locked, frame_done, frame_ok, overflow;
    logic [4:0]  col_count;
    logic [15:0] mismatch_mask, frame_cnt, err_cnt;

    always #5 clk = ~clk;

    heart_pattern_decoder #(
        .NUM_COLS  (12),
        .BLANK_RUN (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .signal1       (sig[0]),
        .signal2       (sig[1]),
        .signal3       (sig[2]),
        .signal4       (sig[3]),
        .signal5       (sig[4]),
        .signal6       (sig[5]),
        .signal7       (sig[6]),
        .signal8       (sig[7]),
        .signal9       (sig[8]),
        .signal10      (sig[9]),
        .signal11      (sig[10]),
        .signal12      (sig[11]),
        .locked        (locked),
        .frame_done    (frame_done),
        .frame_ok      (frame_ok),
        .col_count     (col_count),
        .mismatch_mask (mismatch_mask),
        .frame_cnt     (frame_cnt),
        .err_cnt       (err_cnt),
        .overflow      (overflow)
    );

    logic [11:0] exp_cols [12] = '{12'h038, 12'h07C, 12'h0FE, 12'h1FE, 12'h3FC, 12'h7F8,
                                   12'h7F8, 12'h3FC, 12'h1FE, 12'h0FE, 12'h07C, 12'h038};

    typedef struct {
        bit          ovf;
        bit          ok;
        logic [4:0]  cnt;
        logic [15:0] mask;
        logic [15:0] fcnt;
        logic [15:0] ecnt;
    } exp_t;

    exp_t        sb [$];
    int          checks = 0;
    int          failures = 0;
    logic [15:0] m_fcnt = '0, m_ecnt = '0, m_mask = '0;
    logic [4:0]  m_cnt = '0;
    bit          m_ok = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, expv);
        end
    endtask

    task automatic step(input logic [11:0] c);
        sig = c;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_fcnt = '0; m_ecnt = '0; m_mask = '0; m_cnt = '0; m_ok = 1'b0;
    endtask

    // n columns (col bad_col replaced by bad_val), then the terminating blank.
    task automatic send_frame(input int n, input int bad_col, input logic [11:0] bad_val,
                              input logic [15:0] exp_mask);
        exp_t e;
        for (int k = 0; k < n; k++)
            step((k == bad_col) ? bad_val : exp_cols[k % 12]);
        if (n > 12) begin
            m_ecnt = m_ecnt + 16'd1;
            e = '{ovf: 1'b1, ok: m_ok, cnt: m_cnt, mask: m_mask, fcnt: m_fcnt, ecnt: m_ecnt};
            sb.push_back(e);
            step(12'h000);
            chk("ovf_pulse", 32'(overflow), 32'd1);
            chk("ovf_unlocked", 32'(locked), 32'd0);
        end else begin
            m_ok   = (exp_mask == '0) && (n == 12);
            m_cnt  = 5'(n);
            m_mask = exp_mask;
            m_fcnt = m_fcnt + 16'd1;
            if (!m_ok) m_ecnt = m_ecnt + 16'd1;
            e = '{ovf: 1'b0, ok: m_ok, cnt: m_cnt, mask: m_mask, fcnt: m_fcnt, ecnt: m_ecnt};
            sb.push_back(e);
            step(12'h000);
            chk("done_lat1", 32'(frame_done), 32'd0);
            step(12'h000);
            chk("done_lat2", 32'(frame_done), 32'd1);
        end
    endtask

    task automatic wait_lock(input string name);
        for (int i = 0; i < 10 && !locked; i++)
            step(12'h000);
        chk(name, 32'(locked), 32'd1);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset && (frame_done || overflow)) begin
                if (sb.size() == 0) begin
                    chk("unexpected_report", {30'd0, overflow, frame_done}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("report_kind", {30'd0, overflow, frame_done}, e.ovf ? 32'd2 : 32'd1);
                    chk("frame_ok", 32'(frame_ok), 32'(e.ok));
                    chk("col_count", 32'(col_count), 32'(e.cnt));
                    chk("mismatch_mask", 32'(mismatch_mask), 32'(e.mask));
                    chk("frame_cnt", 32'(frame_cnt), 32'(e.fcnt));
                    chk("err_cnt", 32'(err_cnt), 32'(e.ecnt));
                    chk("locked_at_report", 32'(locked), e.ovf ? 32'd0 : 32'd1);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timed out");
    end

    initial begin : stimulus
        // Reset held with random inputs: every output stays cleared.
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sig = 12'($urandom);
            @(posedge clk);
            #1;
        end
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_frame_ok", 32'(frame_ok), 32'd0);
        chk("rst_col_count", 32'(col_count), 32'd0);
        chk("rst_mask", 32'(mismatch_mask), 32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);

        sig = '0;
        reset = 1'b1;
        step(12'h000);
        chk("lock_clk1", 32'(locked), 32'd0);
        step(12'h000);
        chk("lock_clk2", 32'(locked), 32'd0);
        step(12'h000);
        chk("lock_clk3", 32'(locked), 32'd1);

        send_frame(12, -1, 12'h000, 16'h0000);
        step(12'h000);
        send_frame(12, 5, 12'h7F0, 16'h0020);
        step(12'h000);
        send_frame(10, -1, 12'h000, 16'h0C00);
        step(12'h000);
        send_frame(13, -1, 12'h000, 16'h0000);
        wait_lock("relock_after_ovf");
        send_frame(12, 0, 12'h039, 16'h0001);
        step(12'h000);

        // Fresh reset, then a stream of clean frames with 2-blank gaps.
        #2 reset = 1'b0;
        step(12'h000);
        step(12'h000);
        chk("rst2_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("rst2_err_cnt", 32'(err_cnt), 32'd0);
        model_reset();
        reset = 1'b1;
        wait_lock("lock_stream");
        for (int f = 0; f < 12; f++)
            send_frame(12, -1, 12'h000, 16'h0000);
        chk("stream_err_cnt", 32'(err_cnt), 32'd0);

        // Reset lands mid-frame: that frame must never be reported.
        for (int k = 0; k < 6; k++)
            step(exp_cols[k]);
        #2 reset = 1'b0;
        step(exp_cols[6]);
        step(exp_cols[7]);
        chk("midrst_locked", 32'(locked), 32'd0);
        chk("midrst_frame_cnt", 32'(frame_cnt), 32'd0);
        model_reset();
        reset = 1'b1;
        for (int k = 8; k < 12; k++)
            step(exp_cols[k]);
        step(12'h000);
        step(12'h000);
        chk("midrst_no_done", 32'(frame_done), 32'd0);
        wait_lock("relock_after_rst");
        for (int f = 0; f < 8; f++)
            send_frame(12, -1, 12'h000, 16'h0000);
        chk("final_frame_cnt", 32'(frame_cnt), 32'd8);
        chk("final_err_cnt", 32'(err_cnt), 32'd0);

        for (int i = 0; i < 4; i++)
            step(12'h000);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
